ps2_key_tracker: RTL and testbench

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

---
 rtl/ps2_key_tracker.sv | 184 ++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : ps2_key_tracker                                               |
// | Purpose  : Set-2 scan decoder with held-key bitmap and key event queue.  |
// |            Define PS2_KEY_FIFO_EN for a FIFO_DEPTH-entry event FIFO;     |
// |            otherwise a single-entry holding register is built.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ps2_key_tracker #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       key_valid,
   input  logic [7:0] key_data,
   input  logic       pop,
   input  logic       clr_ovf,
   output logic [7:0] held_keys,
   output logic [9:0] event_data,
   output logic       event_valid,
   output logic [4:0] event_count,
   output logic       overflow
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_EXT     = 2'd1;
   localparam logic [1:0] S_BRK     = 2'd2;
   localparam logic [1:0] S_EXT_BRK = 2'd3;

   logic [1:0] r_state, w_state_nxt;
   logic       w_push, w_brk, w_ext, w_is_prefix, w_is_ignored;
   logic [9:0] w_event;
   logic       w_do_pop, w_ovf_set, w_valid_nxt;
   logic [9:0] w_head_nxt;
   logic [4:0] w_count_nxt;
   logic [7:0] r_held, r_count_unused_guard;
   logic [9:0] r_event_data;
   logic       r_event_valid, r_overflow;
   logic [4:0] r_count;

   assign w_is_prefix  = (key_data == 8'hE0) || (key_data == 8'hF0);
   assign w_is_ignored = (key_data == 8'hAA) || (key_data == 8'hFA) || (key_data == 8'hEE) ||
                         (key_data == 8'hFC) || (key_data == 8'hFE) || (key_data == 8'h00);
   assign w_event      = {w_brk, w_ext, key_data};

   function automatic logic [7:0] key_mask(input logic ext, input logic [7:0] code);
      case ({ext, code})
         9'h01D:  key_mask = 8'h01;
         9'h01B:  key_mask = 8'h02;
         9'h175:  key_mask = 8'h04;
         9'h172:  key_mask = 8'h08;
         9'h029:  key_mask = 8'h10;
         9'h05A:  key_mask = 8'h20;
         9'h076:  key_mask = 8'h40;
         9'h04D:  key_mask = 8'h80;
         default: key_mask = 8'h00;
      endcase
   endfunction

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (key_valid) begin
         case (r_state)
            S_IDLE: begin
               if (key_data == 8'hE0)      w_state_nxt = S_EXT;
               else if (key_data == 8'hF0) w_state_nxt = S_BRK;
            end
            S_EXT: begin
               if (key_data == 8'hF0)      w_state_nxt = S_EXT_BRK;
               else if (key_data != 8'hE0) w_state_nxt = S_IDLE;
            end
            default: begin
               if (!w_is_prefix)           w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // Stray prefixes inside a sequence are absorbed without producing an event.
   always_comb begin
      w_push = 1'b0;
      w_brk  = 1'b0;
      w_ext  = 1'b0;
      if (key_valid) begin
         case (r_state)
            S_IDLE:    w_push = !w_is_prefix && !w_is_ignored;
            S_EXT:     begin w_push = !w_is_prefix; w_ext = 1'b1; end
            S_BRK:     begin w_push = !w_is_prefix; w_brk = 1'b1; end
            default:   begin w_push = !w_is_prefix; w_brk = 1'b1; w_ext = 1'b1; end
         endcase
      end
   end

`ifdef PS2_KEY_FIFO_EN
   localparam int         c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [4:0] c_depth = 5'(FIFO_DEPTH);

   logic [9:0]         r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr, w_rd_inc;
   logic               w_full, w_do_push;

   assign w_rd_inc = r_rd_ptr + c_ptr_w'(1);

   always_comb begin
      w_do_pop    = pop && (r_count != 5'd0);
      w_full      = (r_count == c_depth);
      w_do_push   = w_push && (!w_full || w_do_pop);
      w_ovf_set   = w_push && w_full && !w_do_pop;
      w_count_nxt = r_count + {4'b0, w_do_push} - {4'b0, w_do_pop};
      w_valid_nxt = (w_count_nxt != 5'd0);
      // The registered head must track whichever entry becomes oldest.
      if (!w_valid_nxt)         w_head_nxt = 10'd0;
      else if (w_do_pop)        w_head_nxt = (r_count == 5'd1) ? w_event : r_mem[w_rd_inc];
      else if (r_count == 5'd0) w_head_nxt = w_event;
      else                      w_head_nxt = r_event_data;
   end

   always_ff @(posedge clock) begin
      if (w_do_push) r_mem[r_wr_ptr] <= w_event;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         if (w_do_pop)  r_rd_ptr <= w_rd_inc;
      end
   end
`else
   // Single holding register: a newer event replaces an unread one.
   always_comb begin
      w_do_pop  = pop && r_event_valid;
      w_ovf_set = w_push && r_event_valid && !pop;
      if (w_push) begin
         w_head_nxt  = w_event;
         w_valid_nxt = 1'b1;
      end else if (w_do_pop) begin
         w_head_nxt  = 10'd0;
         w_valid_nxt = 1'b0;
      end else begin
         w_head_nxt  = r_event_data;
         w_valid_nxt = r_event_valid;
      end
      w_count_nxt = {4'b0, w_valid_nxt};
   end
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_event_data  <= 10'd0;
         r_event_valid <= 1'b0;
         r_count       <= 5'd0;
         r_overflow    <= 1'b0;
         r_held        <= 8'h00;
      end else begin
         r_event_data  <= w_head_nxt;
         r_event_valid <= w_valid_nxt;
         r_count       <= w_count_nxt;
         if (w_ovf_set)    r_overflow <= 1'b1;
         else if (clr_ovf) r_overflow <= 1'b0;
         if (w_push) begin
            if (w_brk) r_held <= r_held & ~key_mask(w_ext, key_data);
            else       r_held <= r_held |  key_mask(w_ext, key_data);
         end
      end
   end

   assign r_count_unused_guard = 8'h00;
   assign held_keys   = r_held | r_count_unused_guard;
   assign event_data  = r_event_data;
   assign event_valid = r_event_valid;
   assign event_count = r_count;
   assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_ps2_key_tracker                                            |
// | Purpose  : Directed self-checking bench for ps2_key_tracker.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ps2_key_tracker;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       key_valid = 1'b0;
   logic [7:0] key_data = 8'h00;
   logic       pop = 1'b0;
   logic       clr_ovf = 1'b0;
   logic [7:0] held_keys;
   logic [9:0] event_data;
   logic       event_valid;
   logic [4:0] event_count;
   logic       overflow;
   int         n_cmp = 0;
   int         n_err = 0;

   ps2_key_tracker #(.FIFO_DEPTH(8)) dut (
      .clock(clock), .resetn(resetn), .key_valid(key_valid), .key_data(key_data),
      .pop(pop), .clr_ovf(clr_ovf), .held_keys(held_keys), .event_data(event_data),
      .event_valid(event_valid), .event_count(event_count), .overflow(overflow)
   );

   always #5 clock = ~clock;

   // One clock of stimulus; returns on the falling edge after the capturing edge.
   task automatic drive(input logic kv, input logic [7:0] kd, input logic p, input logic co);
      @(negedge clock);
      key_valid = kv; key_data = kd; pop = p; clr_ovf = co;
      @(negedge clock);
      key_valid = 1'b0; pop = 1'b0; clr_ovf = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (2) @(negedge clock);
      n_cmp++; if (held_keys !== 8'h00) begin n_err++; $display("FAIL rst_held: got %h want 00", held_keys); end
      n_cmp++; if (event_data !== 10'h000) begin n_err++; $display("FAIL rst_data: got %h want 000", event_data); end
      n_cmp++; if (event_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", event_valid); end
      n_cmp++; if (event_count !== 5'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", event_count); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", overflow); end
      resetn = 1'b1;
   endtask

   task automatic test_make_break;
      drive(1'b1, 8'h1D, 1'b0, 1'b0);
      n_cmp++; if (held_keys !== 8'h01) begin n_err++; $display("FAIL mk_held: got %h want 01", held_keys); end
      n_cmp++; if (event_data !== 10'h01D) begin n_err++; $display("FAIL mk_data: got %h want 01D", event_data); end
      n_cmp++; if (event_count !== 5'd1) begin n_err++; $display("FAIL mk_count: got %0d want 1", event_count); end
      n_cmp++; if (event_valid !== 1'b1) begin n_err++; $display("FAIL mk_valid: got %b want 1", event_valid); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      n_cmp++; if (event_data !== 10'h000) begin n_err++; $display("FAIL pop_data: got %h want 000", event_data); end
      n_cmp++; if (event_valid !== 1'b0) begin n_err++; $display("FAIL pop_valid: got %b want 0", event_valid); end
      drive(1'b1, 8'hF0, 1'b0, 1'b0);
      n_cmp++; if (event_count !== 5'd0) begin n_err++; $display("FAIL prefix_count: got %0d want 0", event_count); end
      drive(1'b1, 8'h1D, 1'b0, 1'b0);
      n_cmp++; if (held_keys !== 8'h00) begin n_err++; $display("FAIL brk_held: got %h want 00", held_keys); end
      n_cmp++; if (event_data !== 10'h21D) begin n_err++; $display("FAIL brk_data: got %h want 21D", event_data); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic test_extended;
      drive(1'b1, 8'hE0, 1'b0, 1'b0);
      drive(1'b1, 8'h75, 1'b0, 1'b0);
      n_cmp++; if (held_keys !== 8'h04) begin n_err++; $display("FAIL up_held: got %h want 04", held_keys); end
      n_cmp++; if (event_data !== 10'h175) begin n_err++; $display("FAIL up_data: got %h want 175", event_data); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b1, 8'hE0, 1'b0, 1'b0);
      drive(1'b1, 8'hF0, 1'b0, 1'b0);
      drive(1'b1, 8'h75, 1'b0, 1'b0);
      n_cmp++; if (held_keys !== 8'h00) begin n_err++; $display("FAIL upbrk_held: got %h want 00", held_keys); end
      n_cmp++; if (event_data !== 10'h375) begin n_err++; $display("FAIL upbrk_data: got %h want 375", event_data); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b1, 8'h75, 1'b0, 1'b0);
      n_cmp++; if (held_keys !== 8'h00) begin n_err++; $display("FAIL plain75_held: got %h want 00", held_keys); end
      n_cmp++; if (event_data !== 10'h075) begin n_err++; $display("FAIL plain75_data: got %h want 075", event_data); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic test_ignored;
      drive(1'b1, 8'h1D, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b1, 8'hAA, 1'b0, 1'b0);
      drive(1'b1, 8'hFA, 1'b0, 1'b0);
      n_cmp++; if (event_count !== 5'd0) begin n_err++; $display("FAIL ign_count: got %0d want 0", event_count); end
      n_cmp++; if (event_valid !== 1'b0) begin n_err++; $display("FAIL ign_valid: got %b want 0", event_valid); end
      n_cmp++; if (held_keys !== 8'h01) begin n_err++; $display("FAIL ign_held: got %h want 01", held_keys); end
      drive(1'b1, 8'hF0, 1'b0, 1'b0);
      drive(1'b1, 8'h1D, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

`ifdef PS2_KEY_FIFO_EN
   task automatic test_overflow;
      logic [9:0] exp_head [8];
      exp_head = '{10'h011, 10'h012, 10'h013, 10'h014, 10'h015, 10'h016, 10'h017, 10'h019};
      for (int i = 0; i < 9; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      n_cmp++; if (event_count !== 5'd8) begin n_err++; $display("FAIL full_count: got %0d want 8", event_count); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL full_ovf: got %b want 1", overflow); end
      n_cmp++; if (event_data !== 10'h010) begin n_err++; $display("FAIL full_head: got %h want 010", event_data); end
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf: got %b want 0", overflow); end
      drive(1'b1, 8'h19, 1'b1, 1'b0);
      n_cmp++; if (event_count !== 5'd8) begin n_err++; $display("FAIL pp_count: got %0d want 8", event_count); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pp_ovf: got %b want 0", overflow); end
      n_cmp++; if (event_data !== 10'h011) begin n_err++; $display("FAIL pp_head: got %h want 011", event_data); end
      drive(1'b1, 8'h1A, 1'b0, 1'b1);
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL set_wins: got %b want 1", overflow); end
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (event_data !== exp_head[i]) begin n_err++; $display("FAIL drain_%0d: got %h want %h", i, event_data, exp_head[i]); end
         drive(1'b0, 8'h00, 1'b1, 1'b0);
      end
      n_cmp++; if (event_count !== 5'd0) begin n_err++; $display("FAIL drain_count: got %0d want 0", event_count); end
      n_cmp++; if (event_data !== 10'h000) begin n_err++; $display("FAIL drain_data: got %h want 000", event_data); end
   endtask
`else
   task automatic test_overflow;
      drive(1'b1, 8'h10, 1'b0, 1'b0);
      n_cmp++; if (event_count !== 5'd1) begin n_err++; $display("FAIL hold_count: got %0d want 1", event_count); end
      drive(1'b1, 8'h11, 1'b0, 1'b0);
      n_cmp++; if (event_data !== 10'h011) begin n_err++; $display("FAIL ovw_data: got %h want 011", event_data); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovw_ovf: got %b want 1", overflow); end
      n_cmp++; if (event_count !== 5'd1) begin n_err++; $display("FAIL ovw_count: got %0d want 1", event_count); end
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf: got %b want 0", overflow); end
      drive(1'b1, 8'h12, 1'b1, 1'b0);
      n_cmp++; if (event_data !== 10'h012) begin n_err++; $display("FAIL pp_data: got %h want 012", event_data); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pp_ovf: got %b want 0", overflow); end
      drive(1'b1, 8'h13, 1'b0, 1'b1);
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL set_wins: got %b want 1", overflow); end
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      n_cmp++; if (event_count !== 5'd0) begin n_err++; $display("FAIL drain_count: got %0d want 0", event_count); end
   endtask
`endif

   task automatic test_back_to_back;
      drive(1'b1, 8'h21, 1'b1, 1'b0);
      n_cmp++; if (event_count !== 5'd1) begin n_err++; $display("FAIL empty_pp_count: got %0d want 1", event_count); end
      n_cmp++; if (event_data !== 10'h021) begin n_err++; $display("FAIL empty_pp_data: got %h want 021", event_data); end
      n_cmp++; if (event_valid !== 1'b1) begin n_err++; $display("FAIL empty_pp_valid: got %b want 1", event_valid); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic test_reset_midseq;
      drive(1'b1, 8'h29, 1'b0, 1'b0);
      drive(1'b1, 8'hF0, 1'b0, 1'b0);
      @(negedge clock);
      resetn = 1'b0; key_valid = 1'b1; key_data = 8'h1D; pop = 1'b1;
      #1;
      n_cmp++; if (held_keys !== 8'h00) begin n_err++; $display("FAIL async_held: got %h want 00", held_keys); end
      n_cmp++; if (event_count !== 5'd0) begin n_err++; $display("FAIL async_count: got %0d want 0", event_count); end
      @(negedge clock);
      resetn = 1'b1; key_valid = 1'b0; pop = 1'b0;
      n_cmp++; if (held_keys !== 8'h00) begin n_err++; $display("FAIL inrst_held: got %h want 00", held_keys); end
      drive(1'b1, 8'h29, 1'b0, 1'b0);
      n_cmp++; if (event_data !== 10'h029) begin n_err++; $display("FAIL midseq_data: got %h want 029", event_data); end
      n_cmp++; if (held_keys !== 8'h10) begin n_err++; $display("FAIL midseq_held: got %h want 10", held_keys); end
      n_cmp++; if (event_count !== 5'd1) begin n_err++; $display("FAIL midseq_count: got %0d want 1", event_count); end
   endtask

   initial begin
      test_reset();
      test_make_break();
      test_extended();
      test_ignored();
      test_overflow();
      test_back_to_back();
      test_reset_midseq();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
